// File: rtl/oled_frame_sequencer.sv
// Feeds master_i2c for the SSD1306 128x32 OLED: power-up delay, one init command
// transaction, then 512-byte frame-buffer transactions, one byte per byte_done.
module oled_frame_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 50000,
  parameter logic [6:0]  OLED_ADDR      = 7'h3C,
  parameter int unsigned FB_BYTES       = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh_en,
  input  logic       byte_done,
  input  logic [7:0] fb_data,
  output logic [8:0] fb_addr,
  output logic       start,
  output logic [6:0] addr_byte_out,
  output logic       read_write,
  output logic [7:0] control_byte_out,
  output logic [7:0] data_byte_out,
  output logic       continue_bit,
  output logic       init_done,
  output logic       frame_done,
  output logic       busy
);
  localparam int              DW        = $clog2(POWERUP_CYCLES + 1);
  localparam logic [DW-1:0]   DLY_LAST  = DW'(POWERUP_CYCLES - 1);
  localparam logic [8:0]      FB_LAST   = 9'(FB_BYTES - 1);
  localparam logic [4:0]      INIT_LAST = 5'd30;

  typedef enum logic [2:0] {
    RESET_WAIT, INIT_LOAD, INIT_WAIT, FB_ADDR, FB_LOAD, FB_WAIT, FRAME_END, IDLE
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dly_cnt;
  logic [4:0]      init_idx;
  logic [7:0]      rom_byte;

  assign read_write = 1'b0;
  assign busy       = (state != IDLE);

  // Horizontal addressing over the full 128x32 window, so the panel pointer
  // wraps by itself every 512 bytes and frames need no per-frame addressing.
  always_comb begin
    rom_byte = 8'h00;
    case (init_idx)
      5'd0:  rom_byte = 8'hAE;  5'd1:  rom_byte = 8'hD5;  5'd2:  rom_byte = 8'h80;
      5'd3:  rom_byte = 8'hA8;  5'd4:  rom_byte = 8'h1F;  5'd5:  rom_byte = 8'hD3;
      5'd6:  rom_byte = 8'h00;  5'd7:  rom_byte = 8'h40;  5'd8:  rom_byte = 8'h8D;
      5'd9:  rom_byte = 8'h14;  5'd10: rom_byte = 8'h20;  5'd11: rom_byte = 8'h00;
      5'd12: rom_byte = 8'hA1;  5'd13: rom_byte = 8'hC8;  5'd14: rom_byte = 8'hDA;
      5'd15: rom_byte = 8'h02;  5'd16: rom_byte = 8'h81;  5'd17: rom_byte = 8'h8F;
      5'd18: rom_byte = 8'hD9;  5'd19: rom_byte = 8'hF1;  5'd20: rom_byte = 8'hDB;
      5'd21: rom_byte = 8'h40;  5'd22: rom_byte = 8'hA4;  5'd23: rom_byte = 8'hA6;
      5'd24: rom_byte = 8'h21;  5'd25: rom_byte = 8'h00;  5'd26: rom_byte = 8'h7F;
      5'd27: rom_byte = 8'h22;  5'd28: rom_byte = 8'h00;  5'd29: rom_byte = 8'h03;
      5'd30: rom_byte = 8'hAF;
      default: rom_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET_WAIT: if (dly_cnt == DLY_LAST) state_nxt = INIT_LOAD;
      INIT_LOAD:  state_nxt = INIT_WAIT;
      INIT_WAIT:  if (byte_done) state_nxt = (init_idx == INIT_LAST) ? FB_ADDR : INIT_LOAD;
      FB_ADDR:    state_nxt = FB_LOAD;
      FB_LOAD:    state_nxt = FB_WAIT;
      FB_WAIT:    if (byte_done) state_nxt = (fb_addr == FB_LAST) ? FRAME_END : FB_ADDR;
      FRAME_END:  state_nxt = refresh_en ? FB_ADDR : IDLE;
      IDLE:       if (refresh_en) state_nxt = FB_ADDR;
      default:    state_nxt = RESET_WAIT;
    endcase
  end

  // fb_addr doubles as the frame byte counter; the RAM sees it during FB_ADDR
  // and its read data is registered into data_byte_out in FB_LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_cnt          <= '0;
      init_idx         <= '0;
      fb_addr          <= '0;
      start            <= 1'b0;
      addr_byte_out    <= '0;
      control_byte_out <= 8'h00;
      data_byte_out    <= 8'h00;
      continue_bit     <= 1'b0;
      init_done        <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      addr_byte_out <= OLED_ADDR;
      start         <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        RESET_WAIT: dly_cnt <= dly_cnt + DW'(1);
        INIT_LOAD: begin
          data_byte_out    <= rom_byte;
          control_byte_out <= 8'h00;
          continue_bit     <= (init_idx != INIT_LAST);
          start            <= (init_idx == 5'd0);
        end
        INIT_WAIT: if (byte_done) begin
          init_idx <= init_idx + 5'd1;
          if (init_idx == INIT_LAST) init_done <= 1'b1;
        end
        FB_LOAD: begin
          data_byte_out    <= fb_data;
          control_byte_out <= 8'h40;
          continue_bit     <= (fb_addr != FB_LAST);
          start            <= (fb_addr == 9'd0);
        end
        FB_WAIT: if (byte_done) begin
          if (fb_addr == FB_LAST) frame_done <= 1'b1;
          else                    fb_addr    <= fb_addr + 9'd1;
        end
        FRAME_END: fb_addr      <= '0;
        IDLE:      continue_bit <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
